// File: rtl/mips_defines.sv
// Shared core definitions: datapath widths, NOP encoding and the fetch queue entry layout.
package mips_defines;

  localparam int INST_W          = 32;
  localparam int PC_W            = 32;
  localparam int ENTRY_W         = PC_W + INST_W;
  localparam int INST_FIFO_DEPTH = 4;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo_mem.sv
// DEPTH x {pc,inst} register array: one write port, one asynchronous read port, async clear.
module inst_fifo_mem
  import mips_defines::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [DEPTH-1:0][ENTRY_W-1:0] mem;

  // One register per entry so each slot owns its own clear and write enable.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [ENTRY_W-1:0] q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                          q <= '0;
      else if (we && waddr == PTR_W'(i))    q <= wdata;
    end

    assign mem[i] = q;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fifo.sv
// Instruction queue between fetch (data_ok returns) and decode; flush on redirect.
// Define INST_FIFO_BYPASS_EN for a zero-latency empty-queue bypass path.
module inst_fifo
  import mips_defines::*;
#(
  parameter  int DEPTH = INST_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, push, pop, bypass_take;
  fetch_entry_t     wentry, rentry;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = !full;
  assign wentry   = '{pc: in_pc, inst: in_inst};

`ifdef INST_FIFO_BYPASS_EN
  logic bypass;
  // Empty queue with a fresh response: hand it straight to decode.
  assign bypass      = empty && in_valid && !flush;
  assign bypass_take = bypass && out_ready;
  assign out_valid   = !empty || bypass;
  assign out_pc      = bypass ? in_pc   : (empty ? '0       : rentry.pc);
  assign out_inst    = bypass ? in_inst : (empty ? NOP_INST : rentry.inst);
`else
  assign bypass_take = 1'b0;
  assign out_valid   = !empty;
  assign out_pc      = empty ? '0       : rentry.pc;
  assign out_inst    = empty ? NOP_INST : rentry.inst;
`endif

  // Full queue refuses the push even when a pop drains a slot this cycle.
  assign push = in_valid && in_ready && !bypass_take;
  assign pop  = out_ready && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  inst_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk    (clk),
    .resetn (resetn),
    .we     (push && !flush),
    .waddr  (wr_ptr),
    .wdata  (wentry),
    .raddr  (rd_ptr),
    .rdata  (rentry)
  );

endmodule
